// File: rtl/bus_fifo_pkg.sv
// Shared sizing helpers for the width-converting bus FIFO.
// Derives the storage, pointer and level widths, and clamps the lane count.
package bus_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cap_words(input int depth, input int ratio);
        return depth * ratio;
    endfunction

    // Keep at least one pointer bit so a single-slot build still elaborates.
    function automatic int ptr_width(input int cap);
        return (clog2(cap) < 1) ? 1 : clog2(cap);
    endfunction

    function automatic int lvl_width(input int cap);
        return clog2(cap + 1);
    endfunction

    function automatic int clamp_lanes(input int lanes, input int ratio);
        return (lanes > ratio) ? ratio : lanes;
    endfunction

endpackage

// File: rtl/bus_fifo_ram.sv
// Purpose: CAP x RD_W storage with one write port per lane and an async read port.
// Latency: writes land on the clock edge; the read port is combinational.
// Backpressure: none; the caller gates the per-lane write enables.
module bus_fifo_ram #(
    parameter int RD_W  = 64,
    parameter int RATIO = 2,
    parameter int CAP   = 16,
    parameter int PTR_W = 4
) (
    input  logic                    clk,
    input  logic [RATIO-1:0]        we,
    input  logic [RATIO*PTR_W-1:0]  waddr,
    input  logic [RATIO*RD_W-1:0]   wdata,
    input  logic [PTR_W-1:0]        raddr,
    output logic [RD_W-1:0]         rdata
);

    logic [RD_W-1:0] mem [CAP];

    // Lane addresses are always distinct, so port ordering never matters.
    always_ff @(posedge clk) begin
        for (int k = 0; k < RATIO; k++) begin
            if (we[k]) mem[waddr[k*PTR_W +: PTR_W]] <= wdata[k*RD_W +: RD_W];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_gearbox_fifo.sv
// Purpose: wide RATIO-lane write beats in, FWFT RD_W-bit words out; BUS_FIFO_ERR_EN adds sticky ovf/udf flags.
// Latency: write to rd_valid 1 cycle; pop to next head word 1 cycle; no same-cycle bypass.
// Backpressure: writes are dropped while fifo_full (fewer than RATIO free slots); reads while empty are ignored.
module bus_gearbox_fifo
    import bus_fifo_pkg::*;
#(
    parameter int RD_W  = 64,
    parameter int RATIO = 2,
    parameter int DEPTH = 8,
    localparam int CAP    = cap_words(DEPTH, RATIO),
    localparam int PTR_W  = ptr_width(CAP),
    localparam int LVL_W  = lvl_width(CAP),
    localparam int LANE_W = clog2(RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [RD_W*RATIO-1:0] wr_data,
    input  logic [LANE_W-1:0]     wr_lanes,
    input  logic                  rd_en,
    output logic [RD_W-1:0]       rd_data,
    output logic                  rd_valid,
    output logic                  fifo_full,
    output logic                  fifo_half_full,
    output logic                  fifo_empty,
    output logic [LVL_W-1:0]      fifo_level
`ifdef BUS_FIFO_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  udf_err
`endif
);

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [LANE_W-1:0]      lanes_c;
    logic                   wr_accept;
    logic                   pop;
    logic [LVL_W-1:0]       added;
    logic [RATIO-1:0]       lane_we;
    logic [RATIO*PTR_W-1:0] lane_addr;

    assign lanes_c   = LANE_W'(clamp_lanes(int'(wr_lanes), RATIO));
    assign wr_accept = wr_en && (wr_lanes != '0) && !fifo_full;
    assign pop       = rd_en && !fifo_empty;
    assign added     = wr_accept ? LVL_W'(lanes_c) : '0;

    always_comb begin
        lane_we   = '0;
        lane_addr = '0;
        for (int k = 0; k < RATIO; k++) begin
            lane_we[k]                   = wr_accept && (k < int'(lanes_c));
            lane_addr[k*PTR_W +: PTR_W]  = wr_ptr + PTR_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(lanes_c);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + added - LVL_W'(pop);
        end
    end

    bus_fifo_ram #(
        .RD_W  (RD_W),
        .RATIO (RATIO),
        .CAP   (CAP),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (lane_we),
        .waddr (lane_addr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Full means a whole beat might not fit, so a partial beat is also refused.
    assign fifo_full      = level > LVL_W'(CAP - RATIO);
    assign fifo_half_full = level >= LVL_W'(CAP / 2);
    assign fifo_empty     = (level == '0);
    assign rd_valid       = !fifo_empty;
    assign fifo_level     = level;

`ifdef BUS_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_en && (wr_lanes != '0) && fifo_full) ovf_err <= 1'b1;
            if (rd_en && fifo_empty)                     udf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_gearbox_fifo.sv
// Directed bench for bus_gearbox_fifo at default parameters (RD_W=64, RATIO=2, DEPTH=8).
module tb_bus_gearbox_fifo;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [127:0] wr_data;
    logic [1:0]   wr_lanes;
    logic         rd_en;
    logic [63:0]  rd_data;
    logic         rd_valid;
    logic         fifo_full;
    logic         fifo_half_full;
    logic         fifo_empty;
    logic [4:0]   fifo_level;
`ifdef BUS_FIFO_ERR_EN
    logic         ovf_err;
    logic         udf_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    bus_gearbox_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_lanes       (wr_lanes),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .fifo_full      (fifo_full),
        .fifo_half_full (fifo_half_full),
        .fifo_empty     (fifo_empty),
        .fifo_level     (fifo_level)
`ifdef BUS_FIFO_ERR_EN
        ,
        .ovf_err        (ovf_err),
        .udf_err        (udf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] hi, input logic [63:0] lo, input logic [1:0] lanes);
        wr_en    = 1'b1;
        wr_data  = {hi, lo};
        wr_lanes = lanes;
        tick();
        wr_en    = 1'b0;
    endtask

    int exp_v;
    int wr_v;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_lanes = 2'd0; rd_en = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_half", 64'(fifo_half_full), 64'd0);
`ifdef BUS_FIFO_ERR_EN
        check("rst_ovf", 64'(ovf_err), 64'd0);
        check("rst_udf", 64'(udf_err), 64'd0);
`endif

        // Fill with eight full beats, then one that must be dropped.
        for (int i = 0; i < 8; i++) begin
            put(64'(2*i+1), 64'(2*i), 2'd2);
            if (i == 2) check("half_at_6", 64'(fifo_half_full), 64'd0);
            if (i == 3) check("half_at_8", 64'(fifo_half_full), 64'd1);
            if (i == 6) check("full_at_14", 64'(fifo_full), 64'd0);
        end
        check("fill_full", 64'(fifo_full), 64'd1);
        check("fill_level", 64'(fifo_level), 64'd16);
        put(64'd17, 64'd16, 2'd2);
        check("drop_level", 64'(fifo_level), 64'd16);

        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", 64'(rd_valid), 64'd1);
            check("drain_data", rd_data, 64'(i));
            tick();
        end
        rd_en = 1'b0;
        check("drain_empty", 64'(fifo_empty), 64'd1);
        check("drain_level", 64'(fifo_level), 64'd0);

        // lanes=0 is a no-op; lanes=3 clamps to 2.
        put(64'h77, 64'h66, 2'd0);
        check("lanes0_level", 64'(fifo_level), 64'd0);
        put(64'h31, 64'h30, 2'd3);
        check("clamp_level", 64'(fifo_level), 64'd2);
        rd_en = 1'b1;
        check("clamp_d0", rd_data, 64'h30);
        tick();
        check("clamp_d1", rd_data, 64'h31);
        tick();
        rd_en = 1'b0;
        check("clamp_empty", 64'(fifo_empty), 64'd1);

        // Partial beat: lane 1 of the first beat must never appear.
        put(64'hB, 64'hA, 2'd1);
        put(64'hD, 64'hC, 2'd2);
        check("part_level", 64'(fifo_level), 64'd3);
        rd_en = 1'b1;
        check("part_a", rd_data, 64'hA);
        tick();
        check("part_c", rd_data, 64'hC);
        tick();
        check("part_d", rd_data, 64'hD);
        tick();
        rd_en = 1'b0;
        check("part_empty", 64'(fifo_empty), 64'd1);

        // Concurrent read and write.
        put(64'd1, 64'd0, 2'd2);
        check("conc_d0", rd_data, 64'd0);
        wr_en = 1'b1; wr_data = {64'd3, 64'd2}; wr_lanes = 2'd2; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("conc_peak", 64'(fifo_level), 64'd3);
        check("conc_d1", rd_data, 64'd1);
        tick();
        check("conc_d2", rd_data, 64'd2);
        tick();
        check("conc_d3", rd_data, 64'd3);
        tick();
        rd_en = 1'b0;
        check("conc_empty", 64'(fifo_empty), 64'd1);

        // Streaming across pointer wraps: the output must be a gapless count.
        exp_v = 100; wr_v = 100; rd_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) begin
                wr_en = 1'b1; wr_data = {64'(wr_v + 1), 64'(wr_v)}; wr_lanes = 2'd2;
                wr_v += 2;
            end else begin
                wr_en = 1'b0;
            end
            if (rd_valid) begin
                check("wrap_data", rd_data, 64'(exp_v));
                exp_v++;
            end
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 8 && rd_valid; c++) begin
            check("wrap_tail", rd_data, 64'(exp_v));
            exp_v++;
            tick();
        end
        rd_en = 1'b0;
        check("wrap_count", 64'(exp_v), 64'(wr_v));
        check("wrap_empty", 64'(fifo_empty), 64'd1);

        // Reset in the middle of a burst discards everything.
        for (int i = 0; i < 3; i++) put(64'(50 + 2*i + 1), 64'(50 + 2*i), 2'd2);
        check("mid_level", 64'(fifo_level), 64'd6);
        rst = 1'b1; wr_en = 1'b1; wr_data = {64'd99, 64'd98}; wr_lanes = 2'd2;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_empty", 64'(fifo_empty), 64'd1);
        put(64'd5, 64'd4, 2'd2);
        rd_en = 1'b1;
        check("mid_d4", rd_data, 64'd4);
        tick();
        check("mid_d5", rd_data, 64'd5);
        tick();
        rd_en = 1'b0;
        check("mid_empty", 64'(fifo_empty), 64'd1);

`ifdef BUS_FIFO_ERR_EN
        check("err_udf_clear", 64'(udf_err), 64'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("err_udf_set", 64'(udf_err), 64'd1);
        for (int i = 0; i < 8; i++) put(64'(2*i+1), 64'(2*i), 2'd2);
        check("err_ovf_clear", 64'(ovf_err), 64'd0);
        put(64'd17, 64'd16, 2'd2);
        check("err_ovf_set", 64'(ovf_err), 64'd1);
        tick();
        tick();
        check("err_ovf_sticky", 64'(ovf_err), 64'd1);
        check("err_udf_sticky", 64'(udf_err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_ovf_rst", 64'(ovf_err), 64'd0);
        check("err_udf_rst", 64'(udf_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
